// File: rtl/sdram_responder.sv
// ---------------------------------------------------------------------------
// sdram_responder
//   Behavioural SDRAM device model for controller bring-up. Decodes the
//   standard SDR command set, tracks per-bank open rows, stores write data
//   with byte masks, returns read data after the active CAS latency, and
//   raises a sticky error flag on protocol violations (err_code holds the
//   first one seen):
//     1 ACTIVE to an open bank        2 READ/WRITE to an idle bank
//     3 REFRESH/LOAD MODE, bank open  4 illegal LOAD MODE value
//     5 WRITE while read data is due  6 tRCD violation   7 tRP violation
//   Codes 6 and 7 exist only when SDRAM_RESPONDER_TIMING_CHECK_EN is defined.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   sdram_addr[12:0]        row / column / mode address
//   sdram_ba[1:0]           bank select
//   sdram_cs_n/ras_n/cas_n/we_n, sdram_cke   command encoding
//   sdram_dqm[1:0]          write byte masks (bit 0 masks dq[7:0])
//   sdram_dq[15:0]          bidirectional data, driven only for read data
//   mode_loaded             a legal LOAD MODE has been accepted
//   cur_cl[1:0]             active CAS latency (2 or 3)
//   err, err_code[2:0]      sticky violation flag and first violation code
// ---------------------------------------------------------------------------
module sdram_responder #(
   parameter int CAS_LATENCY = 3,
   parameter int ROW_BITS    = 2,
   parameter int COL_BITS    = 8,
   parameter int TRCD_CYC    = 3,
   parameter int TRP_CYC     = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [12:0] sdram_addr,
   input  logic [1:0]  sdram_ba,
   input  logic        sdram_cs_n,
   input  logic        sdram_ras_n,
   input  logic        sdram_cas_n,
   input  logic        sdram_we_n,
   input  logic        sdram_cke,
   input  logic [1:0]  sdram_dqm,
   inout  wire  [15:0] sdram_dq,
   output logic        mode_loaded,
   output logic [1:0]  cur_cl,
   output logic        err,
   output logic [2:0]  err_code
);

   localparam int MEM_AW = 2 + ROW_BITS + COL_BITS;

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACTIVE, CMD_READ, CMD_WRITE,
      CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE, CMD_BURST_TERM
   } cmd_e;

   localparam logic [2:0] ERR_NONE        = 3'd0;
   localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
   localparam logic [2:0] ERR_IDLE_ACCESS = 3'd2;
   localparam logic [2:0] ERR_BANK_OPEN   = 3'd3;
   localparam logic [2:0] ERR_BAD_MODE    = 3'd4;
   localparam logic [2:0] ERR_DQ_CONFLICT = 3'd5;
   localparam logic [2:0] ERR_TRCD        = 3'd6;
   localparam logic [2:0] ERR_TRP         = 3'd7;

   cmd_e                cmd;
   logic [3:0]          bank_active;
   logic [ROW_BITS-1:0] open_row [4];
   logic [15:0]         mem [2**MEM_AW];
   logic [MEM_AW-1:0]   mem_idx;
   logic                bank_open, mode_ok, trcd_viol, trp_viol;
   logic                act_fire, rd_fire, wr_fire, load_fire;
   logic [3:0]          pre_hit;
   logic [2:0]          viol;
   // Read pipeline: entries enter at stage cur_cl-1 and drain toward stage 0,
   // whose content is registered onto dq on the next edge.
   logic [2:0]          pipe_vld;
   logic [15:0]         pipe_data [3];
   logic                dq_oe;
   logic [15:0]         dq_out;
   logic                unused_ok;

   assign unused_ok = ^{sdram_addr, 1'(TRCD_CYC), 1'(TRP_CYC)};

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      cmd = CMD_NOP;
      if (!sdram_cs_n && sdram_cke) begin
         case ({sdram_ras_n, sdram_cas_n, sdram_we_n})
            3'b011:  cmd = CMD_ACTIVE;
            3'b101:  cmd = CMD_READ;
            3'b100:  cmd = CMD_WRITE;
            3'b010:  cmd = CMD_PRECHARGE;
            3'b001:  cmd = CMD_REFRESH;
            3'b000:  cmd = CMD_LOAD_MODE;
            3'b110:  cmd = CMD_BURST_TERM;
            default: cmd = CMD_NOP;
         endcase
      end
   end

   assign bank_open = bank_active[sdram_ba];
   assign mem_idx   = {sdram_ba, open_row[sdram_ba], sdram_addr[COL_BITS-1:0]};
   assign mode_ok   = (sdram_addr[2:0] == 3'b000) &&
                      ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3));

   assign act_fire  = (cmd == CMD_ACTIVE) && !bank_open;
   assign rd_fire   = (cmd == CMD_READ)   && bank_open;
   assign wr_fire   = (cmd == CMD_WRITE)  && bank_open;
   assign load_fire = (cmd == CMD_LOAD_MODE) && !(|bank_active) && mode_ok;

   always_comb begin
      for (int b = 0; b < 4; b++)
         pre_hit[b] = (cmd == CMD_PRECHARGE) && (sdram_addr[10] || (sdram_ba == 2'(b)));
   end

   always_comb begin
      viol = ERR_NONE;
      case (cmd)
         CMD_ACTIVE:
            if (bank_open)     viol = ERR_ACT_OPEN;
            else if (trp_viol) viol = ERR_TRP;
         CMD_READ, CMD_WRITE:
            if (!bank_open)                        viol = ERR_IDLE_ACCESS;
            else if ((cmd == CMD_WRITE) && dq_oe)  viol = ERR_DQ_CONFLICT;
            else if (trcd_viol)                    viol = ERR_TRCD;
         CMD_REFRESH:
            if (|bank_active) viol = ERR_BANK_OPEN;
         CMD_LOAD_MODE:
            if (|bank_active)  viol = ERR_BANK_OPEN;
            else if (!mode_ok) viol = ERR_BAD_MODE;
         default: viol = ERR_NONE;
      endcase
   end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
   localparam int CNT_MAX = (TRCD_CYC > TRP_CYC) ? TRCD_CYC : TRP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

   // Clocks elapsed since the last ACTIVE / PRECHARGE per bank, saturating.
   logic [CNT_W-1:0] since_act [4];
   logic [CNT_W-1:0] since_pre [4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 4; b++) begin
            since_act[b] <= CNT_W'(CNT_MAX);
            since_pre[b] <= CNT_W'(CNT_MAX);
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (act_fire && (sdram_ba == 2'(b)))      since_act[b] <= CNT_W'(1);
            else if (since_act[b] != CNT_W'(CNT_MAX)) since_act[b] <= since_act[b] + CNT_W'(1);
            if (pre_hit[b])                           since_pre[b] <= CNT_W'(1);
            else if (since_pre[b] != CNT_W'(CNT_MAX)) since_pre[b] <= since_pre[b] + CNT_W'(1);
         end
      end
   end

   assign trcd_viol = since_act[sdram_ba] < CNT_W'(TRCD_CYC);
   assign trp_viol  = since_pre[sdram_ba] < CNT_W'(TRP_CYC);
`else
   assign trcd_viol = 1'b0;
   assign trp_viol  = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_active <= '0;
         for (int b = 0; b < 4; b++) open_row[b] <= '0;
         pipe_vld    <= '0;
         for (int s = 0; s < 3; s++) pipe_data[s] <= '0;
         dq_oe       <= 1'b0;
         dq_out      <= '0;
         mode_loaded <= 1'b0;
         cur_cl      <= 2'(CAS_LATENCY);
         err         <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         if (act_fire) begin
            bank_active[sdram_ba] <= 1'b1;
            open_row[sdram_ba]    <= sdram_addr[ROW_BITS-1:0];
         end
         for (int b = 0; b < 4; b++)
            if (pre_hit[b]) bank_active[b] <= 1'b0;

         dq_oe        <= pipe_vld[0];
         dq_out       <= pipe_data[0];
         pipe_vld     <= {1'b0, pipe_vld[2:1]};
         pipe_data[0] <= pipe_data[1];
         pipe_data[1] <= pipe_data[2];
         if (rd_fire) begin
            if (cur_cl == 2'd2) begin
               pipe_vld[1]  <= 1'b1;
               pipe_data[1] <= mem[mem_idx];
            end else begin
               pipe_vld[2]  <= 1'b1;
               pipe_data[2] <= mem[mem_idx];
            end
         end

         if (load_fire) begin
            cur_cl      <= sdram_addr[5:4];
            mode_loaded <= 1'b1;
         end

         if (viol != ERR_NONE) begin
            err <= 1'b1;
            if (!err) err_code <= viol;
         end
      end
   end

   // NOTE: the memory array is deliberately not reset; contents survive reset like a real device.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         if (!sdram_dqm[0]) mem[mem_idx][7:0]  <= sdram_dq[7:0];
         if (!sdram_dqm[1]) mem[mem_idx][15:8] <= sdram_dq[15:8];
      end
   end

   // A WRITE owns the bus in its own cycle even if read data was due then.
   assign sdram_dq = (dq_oe && (cmd != CMD_WRITE)) ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sdram_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_responder
//   Directed bench for sdram_responder. Read commands push the expected word
//   and the cycle it must appear in onto a queue; a monitor on the falling
//   edge pops and compares whenever dq is due, and otherwise requires the
//   bus to float (the pull-up makes a released bus read 16'hFFFF).
// ---------------------------------------------------------------------------
module tb_sdram_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] sdram_addr;
   logic [1:0]  sdram_ba;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
   logic [1:0]  sdram_dqm;
   wire  [15:0] sdram_dq;
   logic [15:0] tb_dq;
   logic        tb_dq_en;
   logic        mode_loaded;
   logic [1:0]  cur_cl;
   logic        err;
   logic [2:0]  err_code;

   localparam logic [15:0] FLOAT = 16'hFFFF;

   assign sdram_dq = tb_dq_en ? tb_dq : 16'hzzzz;
   pullup (sdram_dq);

   sdram_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sdram_addr  (sdram_addr),
      .sdram_ba    (sdram_ba),
      .sdram_cs_n  (sdram_cs_n),
      .sdram_ras_n (sdram_ras_n),
      .sdram_cas_n (sdram_cas_n),
      .sdram_we_n  (sdram_we_n),
      .sdram_cke   (sdram_cke),
      .sdram_dqm   (sdram_dqm),
      .sdram_dq    (sdram_dq),
      .mode_loaded (mode_loaded),
      .cur_cl      (cur_cl),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_cl = 3;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } rd_exp_t;
   rd_exp_t exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, got, want, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!tb_dq_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rd_missed: word 0x%0h due in cyc %0d never appeared (now cyc %0d)",
                     exp_q[0].data, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("rd_data", 32'(sdram_dq), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
         end else begin
            check("dq_hiz", 32'(sdram_dq), 32'(FLOAT));
         end
      end
   end

   // Drive one command for one clock, then return to a deselected NOP.
   task automatic drive(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] a,
                        input logic [1:0] m, input logic den, input logic [15:0] d);
      sdram_cs_n = 1'b0;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} = rcw;
      sdram_ba   = b;
      sdram_addr = a;
      sdram_dqm  = m;
      tb_dq_en   = den;
      tb_dq      = d;
      @(posedge clk);
      #1;
      sdram_cs_n = 1'b1;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b111;
      tb_dq_en   = 1'b0;
   endtask

   task automatic nop(input int n);
      repeat (n) drive(3'b111, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic act(input logic [1:0] b, input logic [12:0] row);
      drive(3'b011, b, row, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic pre(input logic [1:0] b, input logic all);
      drive(3'b010, b, {2'b00, all, 10'd0}, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic wr(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d,
                     input logic [1:0] m);
      drive(3'b100, b, col, m, 1'b1, d);
   endtask

   task automatic rd_exp(input logic [1:0] b, input logic [12:0] col, input logic [15:0] d);
      exp_q.push_back('{cyc: cyc + 1 + exp_cl, data: d});
      drive(3'b101, b, col, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic rd_nox(input logic [1:0] b, input logic [12:0] col);
      drive(3'b101, b, col, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic lmr(input logic [12:0] a);
      drive(3'b000, 2'd0, a, 2'b00, 1'b0, 16'h0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_err"},         32'(err),         32'd0);
      check({tag, "_err_code"},    32'(err_code),    32'd0);
      check({tag, "_mode_loaded"}, 32'(mode_loaded), 32'd0);
      check({tag, "_cur_cl"},      32'(cur_cl),      32'd3);
   endtask

   task automatic reset_pulse(input string tag);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_vals(tag);
      reset_n = 1'b1;
      exp_cl  = 3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time (cyc %0d)", cyc);
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      sdram_cke  = 1'b1;
      sdram_cs_n = 1'b1;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} = 3'b111;
      sdram_ba   = '0;
      sdram_addr = '0;
      sdram_dqm  = '0;
      tb_dq      = '0;
      tb_dq_en   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      reset_n = 1'b1;
      nop(2);

      // Basic write/read at CL3
      lmr(13'h030);
      check("lmr30_mode_loaded", 32'(mode_loaded), 32'd1);
      check("lmr30_cur_cl",      32'(cur_cl),      32'd3);
      act(2'd1, 13'd2);
      nop(2);
      wr(2'd1, 13'd5, 16'hBEEF, 2'b00);
      rd_exp(2'd1, 13'd5, 16'hBEEF);
      nop(5);
      check("basic_err", 32'(err), 32'd0);

      // Byte masks
      wr(2'd1, 13'd5, 16'h1234, 2'b01);
      rd_exp(2'd1, 13'd5, 16'h12EF);
      nop(5);
      wr(2'd1, 13'd5, 16'h5678, 2'b10);
      rd_exp(2'd1, 13'd5, 16'h1278);
      nop(5);

      // CL2 and back-to-back reads; row aliasing above ROW_BITS
      pre(2'd0, 1'b1);
      nop(2);
      lmr(13'h020);
      exp_cl = 2;
      check("lmr20_cur_cl", 32'(cur_cl), 32'd2);
      act(2'd0, 13'd1);
      nop(2);
      wr(2'd0, 13'd0, 16'hA001, 2'b00);
      wr(2'd0, 13'd1, 16'hA002, 2'b00);
      wr(2'd0, 13'd2, 16'hA003, 2'b00);
      wr(2'd0, 13'd3, 16'hA004, 2'b00);
      rd_exp(2'd0, 13'd0, 16'hA001);
      rd_exp(2'd0, 13'd1, 16'hA002);
      rd_exp(2'd0, 13'd2, 16'hA003);
      rd_exp(2'd0, 13'd3, 16'hA004);
      nop(4);
      pre(2'd0, 1'b0);
      nop(2);
      act(2'd0, 13'd5);
      nop(2);
      rd_exp(2'd0, 13'd0, 16'hA001);
      nop(4);
      check("b2b_err", 32'(err), 32'd0);

      // Idle-bank read, then first-error latching
      rd_nox(2'd2, 13'd0);
      check("idle_rd_err",      32'(err),      32'd1);
      check("idle_rd_err_code", 32'(err_code), 32'd2);
      act(2'd1, 13'd2);
      check("act_after_code", 32'(err_code), 32'd2);
      act(2'd1, 13'd3);
      nop(1);
      rd_exp(2'd1, 13'd5, 16'h1278);
      nop(4);
      check("latched_code", 32'(err_code), 32'd2);

      // Refresh with a bank open
      reset_pulse("rst1");
      act(2'd3, 13'd0);
      nop(2);
      drive(3'b001, 2'd0, 13'd0, 2'b00, 1'b0, 16'h0);
      check("ref_open_code", 32'(err_code), 32'd3);

      // Illegal mode values leave the mode untouched
      reset_pulse("rst2");
      lmr(13'h040);
      check("lmr_cl4_code",   32'(err_code),    32'd4);
      check("lmr_cl4_cur_cl", 32'(cur_cl),      32'd3);
      check("lmr_cl4_loaded", 32'(mode_loaded), 32'd0);
      lmr(13'h021);
      check("lmr_bl2_cur_cl", 32'(cur_cl), 32'd3);
      lmr(13'h020);
      check("lmr_ok_cur_cl", 32'(cur_cl),      32'd2);
      check("lmr_ok_loaded", 32'(mode_loaded), 32'd1);
      check("lmr_ok_code",   32'(err_code),    32'd4);

      // Write colliding with scheduled read data (CL3)
      reset_pulse("rst3");
      act(2'd1, 13'd2);
      nop(2);
      rd_nox(2'd1, 13'd5);
      nop(3);
      wr(2'd1, 13'd7, 16'h4321, 2'b00);
      check("conflict_code", 32'(err_code), 32'd5);
      rd_exp(2'd1, 13'd7, 16'h4321);
      nop(5);

      // Reset while a read is in flight
      rd_nox(2'd1, 13'd5);
      reset_pulse("rst4");
      nop(6);
      check_reset_vals("post_rst4");
      act(2'd1, 13'd2);
      nop(2);
      rd_exp(2'd1, 13'd5, 16'h1278);
      rd_exp(2'd1, 13'd7, 16'h4321);
      nop(5);

      // Command spacing
      act(2'd2, 13'd0);
      nop(2);
      wr(2'd2, 13'd0, 16'hC0DE, 2'b00);
      pre(2'd2, 1'b0);
      nop(2);
      act(2'd2, 13'd0);
      rd_exp(2'd2, 13'd0, 16'hC0DE);
      nop(1);
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      check("trcd_code", 32'(err_code), 32'd6);
`else
      check("trcd_no_err", 32'(err), 32'd0);
`endif
      nop(4);
      reset_pulse("rst5");
      pre(2'd2, 1'b0);
      act(2'd2, 13'd0);
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
      check("trp_code", 32'(err_code), 32'd7);
`else
      check("trp_no_err", 32'(err), 32'd0);
`endif
      nop(8);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requires

Module: sdram_responder

Interface
REQ-001 SHALL provide parameter CAS_LATENCY, default 3, read latency used until a Load Mode command is accepted (legal values 2 or 3).
REQ-002 SHALL provide parameter ROW_BITS, default 2, number of low row-address bits actually stored; upper row bits alias.
REQ-003 SHALL provide parameter COL_BITS, default 8, number of low column-address bits actually stored.
REQ-004 SHALL provide parameters TRCD_CYC, default 3, and TRP_CYC, default 3, minimum command spacing in clocks.
REQ-005 SHALL have ports: clk  in  1  single clock, all inputs sampled on rising edge.
REQ-006 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: sdram_addr  in  13  row/column/mode address; sdram_ba  in  2  bank select.
REQ-008 SHALL have ports: sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command encoding.
REQ-009 SHALL have ports: sdram_cke  in  1  clock enable; sdram_dqm  in  2  write byte masks, bit 0 masks dq[7:0].
REQ-010 SHALL have ports: sdram_dq  inout  16  data; high-Z unless read data is being driven.
REQ-011 SHALL have ports: mode_loaded  out  1  a legal Load Mode was accepted; cur_cl  out  2  active CAS latency.
REQ-012 SHALL have ports: err  out  1  sticky protocol-violation flag; err_code  out  3  code of first violation.

Function
REQ-013 SHALL decode {ras_n,cas_n,we_n} with cs_n=0 and cke=1 as follows: 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 110 BURST TERMINATE, 111 NOP.
REQ-014 SHALL treat cs_n=1 or cke=0 as NOP; the read pipeline still advances.
REQ-015 SHALL keep a per-bank state IDLE/ACTIVE plus an open-row register.
REQ-016 ACTIVE on an IDLE bank SHALL open row addr[ROW_BITS-1:0]; ACTIVE on an ACTIVE bank SHALL set err (code 1), and the state SHALL be unchanged.
REQ-017 PRECHARGE SHALL idle bank ba, or all banks when addr[10]=1; PRECHARGE of an idle bank is legal.
REQ-018 WRITE on an ACTIVE bank SHALL store sdram_dq in the same cycle at {ba,open row,addr[COL_BITS-1:0]}, with bytes whose dqm bit is 1 left unchanged.
REQ-019 READ on an ACTIVE bank SHALL drive the stored word on sdram_dq for exactly one cycle, starting cur_cl clocks after the command; back-to-back READs every cycle SHALL be supported.
REQ-020 READ or WRITE on an IDLE bank SHALL set err (code 2); no memory update and no dq drive SHALL occur.
REQ-021 AUTO REFRESH or LOAD MODE with any bank ACTIVE SHALL set err (code 3) and be ignored.
REQ-022 LOAD MODE SHALL accept addr[6:4] of 2 or 3 as the new cur_cl when addr[2:0]=000 (burst length 1), and set mode_loaded.
  - Any other value SHALL set err (code 4) and leave the mode unchanged.
REQ-023 A WRITE in a cycle where read data is scheduled on dq SHALL set err (code 5); the write SHALL still commit, and dq SHALL NOT be driven that cycle.
REQ-024 BURST TERMINATE SHALL be accepted as a NOP, since all bursts are length 1.
REQ-025 err_code SHALL latch only the first violation; later violations SHALL leave it unchanged.

Reset
REQ-026 reset_n low SHALL asynchronously force the following state:
  - all banks IDLE and the read pipeline empty;
  - dq high-Z;
  - err=0, err_code=0, mode_loaded=0, cur_cl=CAS_LATENCY.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Reset asserted mid-read SHALL cancel pending read data; no dq drive SHALL follow the reset release.

Configuration
REQ-029 With macro SDRAM_RESPONDER_TIMING_CHECK_EN defined, the block SHALL enforce command spacing:
  - READ/WRITE fewer than TRCD_CYC clocks after ACTIVE to the same bank SHALL set err (code 6);
  - ACTIVE fewer than TRP_CYC clocks after PRECHARGE of that bank SHALL set err (code 7);
  - the offending command SHALL still execute.
REQ-030 Without SDRAM_RESPONDER_TIMING_CHECK_EN, no spacing counters SHALL exist, and codes 6 and 7 SHALL never occur.

Verification
REQ-031 LOAD MODE addr=0x030, then ACTIVE ba=1 row=2, WRITE col=5 dq=0xBEEF, READ col=5 -> dq=0xBEEF exactly 3 clocks after READ, high-Z otherwise, err=0.
REQ-032 Stored word 0xBEEF, WRITE dq=0x1234 with dqm=01, then READ -> dq=0x12EF.
REQ-033 READ to idle bank 2 -> err=1, err_code=2, dq stays high-Z; a following ACTIVE to bank 1 -> err_code still 2.
REQ-034 LOAD MODE addr=0x020, then four READs on consecutive cycles to cols 0-3 -> four consecutive dq words starting 2 clocks after the first READ.
REQ-035 READ issued, reset_n pulsed low 1 cycle later -> no dq drive afterwards, all outputs at reset values, earlier written data still readable.
REQ-036 With SDRAM_RESPONDER_TIMING_CHECK_EN: ACTIVE then READ 1 clock later -> err_code=6, and read data is still returned.
